// File: rtl/lcd_timing_pkg.sv
// Shared timing constants, derived totals and types for the 800x480 LCD timing controller.
package lcd_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE  = 800;
  localparam int unsigned DEF_H_SYNC    = 1;
  localparam int unsigned DEF_H_BP      = 46;
  localparam int unsigned DEF_H_FP      = 209;
  localparam int unsigned DEF_V_ACTIVE  = 480;
  localparam int unsigned DEF_V_SYNC    = 1;
  localparam int unsigned DEF_V_BP      = 23;
  localparam int unsigned DEF_V_FP      = 21;
  localparam int unsigned DEF_GREST_DLY = 1000;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_H_START = DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_H_STOP  = DEF_H_START + DEF_H_ACTIVE;
  localparam int unsigned DEF_V_START = DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_V_STOP  = DEF_V_START + DEF_V_ACTIVE;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Everything the panel and the pixel datapath see, registered as one word.
  typedef struct packed {
    logic           hd;
    logic           vd;
    logic           den;
    logic           pix_req;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           frame_start;
    logic           running;
  } panel_t;

  localparam panel_t PANEL_RESET = '{
    hd:          1'b1,
    vd:          1'b1,
    den:         1'b0,
    pix_req:     1'b0,
    x_next:      '0,
    y_next:      '0,
    frame_start: 1'b0,
    running:     1'b0
  };

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// Panel timing and pixel look-ahead signals between the timing controller and its consumers.
interface lcd_timing_ctrl_if;
  import lcd_timing_pkg::*;

  logic           ena;
  logic           nclk;
  logic           grest;
  logic           hd;
  logic           vd;
  logic           den;
  logic           pix_ce;
  logic           pix_req;
  logic [X_W-1:0] x_next;
  logic [Y_W-1:0] y_next;
  logic           frame_start;
  logic           running;

  modport master (
    input  ena,
    output nclk, grest, hd, vd, den, pix_ce, pix_req,
    output x_next, y_next, frame_start, running
  );

  modport slave (
    output ena,
    input  nclk, grest, hd, vd, den, pix_ce, pix_req,
    input  x_next, y_next, frame_start, running
  );

endinterface

// File: rtl/lcd_axis_counter.sv
// One axis (H or V) of the raster: position counter plus sync/window decode for the
// current position and for the position after the next advance.
module lcd_axis_counter
  import lcd_timing_pkg::*;
#(
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int          CW     = HCNT_W,
  parameter int          IW     = X_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          sync,
  output logic          window,
  output logic          next_window,
  output logic [IW-1:0] next_index
);

  localparam int unsigned TOTAL = SYNC + BP + ACTIVE + FP;
  localparam int unsigned START = SYNC + BP;
  localparam int unsigned STOP  = START + ACTIVE;

  localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_C  = CW'(SYNC);
  localparam logic [CW-1:0] START_C = CW'(START);
  localparam logic [CW-1:0] STOP_C  = CW'(STOP);

  logic [CW-1:0] next_count;

  assign wrap        = (count == LAST_C);
  assign next_count  = wrap ? '0 : count + CW'(1);
  assign sync        = (count < SYNC_C);
  assign window      = (count >= START_C) && (count < STOP_C);
  assign next_window = (next_count >= START_C) && (next_count < STOP_C);
  assign next_index  = IW'(next_count - START_C);

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (advance) begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD timing controller: NCLK divider, GREST release delay, IDLE/RUN sequencing and the
// registered HD/VD/DEN plus one-pixel look-ahead for the RGB datapath.
module lcd_timing_ctrl
  import lcd_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned GREST_DLY = DEF_GREST_DLY
) (
  input  logic               clk,
  input  logic               rst_n,
  lcd_timing_ctrl_if.master  bus
);

  localparam int                GREST_W    = $clog2(GREST_DLY) + 1;
  localparam logic [GREST_W-1:0] GREST_LAST = GREST_W'(GREST_DLY - 1);
  localparam logic [VCNT_W-1:0]  V_START_C  = VCNT_W'(V_SYNC + V_BP);

  logic               nclk_q;
  logic               tick;
  logic               grest_q;
  logic [GREST_W-1:0] grest_cnt;
  state_t             state_q, state_d;
  panel_t             out_q, out_d;
  logic               load;
  logic               at_origin;
  logic               req;

  logic [HCNT_W-1:0]  h_count;
  logic               h_wrap, h_sync, h_window, h_next_window;
  logic [X_W-1:0]     h_next_index;
  logic [VCNT_W-1:0]  v_count;
  logic               v_wrap_unused, v_sync, v_window, v_next_window;
  logic [Y_W-1:0]     v_next_index;

  // The tick is the CLK cycle in which NCLK is high; panel outputs move as NCLK falls.
  assign tick = nclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nclk_q <= 1'b0;
    end else begin
      nclk_q <= ~nclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grest_cnt <= '0;
      grest_q   <= 1'b0;
    end else if (!grest_q) begin
      if (grest_cnt == GREST_LAST) begin
        grest_q <= 1'b1;
      end else begin
        grest_cnt <= grest_cnt + GREST_W'(1);
      end
    end
  end

  // Counters run one position ahead of the registered outputs, so their "current"
  // decode is the position being entered and their "next" decode is the look-ahead.
  lcd_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(HCNT_W), .IW(X_W)
  ) u_h (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (load),
    .count       (h_count),
    .wrap        (h_wrap),
    .sync        (h_sync),
    .window      (h_window),
    .next_window (h_next_window),
    .next_index  (h_next_index)
  );

  lcd_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(VCNT_W), .IW(Y_W)
  ) u_v (
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (load && h_wrap),
    .count       (v_count),
    .wrap        (v_wrap_unused),
    .sync        (v_sync),
    .window      (v_window),
    .next_window (v_next_window),
    .next_index  (v_next_index)
  );

  assign at_origin = (h_count == '0) && (v_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= PANEL_RESET;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d             = state_q;
    out_d               = out_q;
    out_d.frame_start   = 1'b0;
    load                = 1'b0;
    req                 = 1'b0;

    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.ena && grest_q) begin
            state_d = ST_RUN;
            load    = 1'b1;
          end
        end
        ST_RUN: begin
          // Counters back at the origin means the frame just finished.
          if (at_origin && !bus.ena) begin
            state_d       = ST_IDLE;
            out_d.hd      = 1'b1;
            out_d.vd      = 1'b1;
            out_d.den     = 1'b0;
            out_d.pix_req = 1'b0;
            out_d.running = 1'b0;
          end else begin
            load = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      req               = h_next_window && (h_wrap ? v_next_window : v_window);
      out_d.hd          = ~h_sync;
      out_d.vd          = ~v_sync;
      out_d.den         = h_window && v_window;
      out_d.running     = 1'b1;
      out_d.frame_start = at_origin;
      out_d.pix_req     = req;
      if (req) begin
        out_d.x_next = h_next_index;
        out_d.y_next = h_wrap ? v_next_index : Y_W'(v_count - V_START_C);
      end
    end
  end

  assign bus.nclk        = nclk_q;
  assign bus.pix_ce      = nclk_q;
  assign bus.grest       = grest_q;
  assign bus.hd          = out_q.hd;
  assign bus.vd          = out_q.vd;
  assign bus.den         = out_q.den;
  assign bus.pix_req     = out_q.pix_req;
  assign bus.x_next      = out_q.x_next;
  assign bus.y_next      = out_q.y_next;
  assign bus.frame_start = out_q.frame_start;
  assign bus.running     = out_q.running;

endmodule

// File: tb/tb_lcd_timing_ctrl.sv
// Self-checking bench for lcd_timing_ctrl on a shrunken raster, against a linear-position
// reference model plus per-frame statistics.
module tb_lcd_timing_ctrl;

  localparam int HS = 2, HB = 3, HA = 8, HF = 4;
  localparam int VS = 1, VB = 2, VA = 5, VF = 2;
  localparam int DLY = 40;
  localparam int HT  = HS + HB + HA + HF;
  localparam int VT  = VS + VB + VA + VF;
  localparam int FT  = HT * VT;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  lcd_timing_ctrl_if bus ();

  lcd_timing_ctrl #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
    .GREST_DLY(DLY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Raster positions are a single linear index p = line*HT + column, wrapping at FT.
  function automatic int nxt(input int p);
    return (p + 1) % FT;
  endfunction

  function automatic bit vis(input int p);
    int h = p % HT;
    int v = p / HT;
    return (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
  endfunction

  function automatic int col(input int p);
    return (p % HT) - HST;
  endfunction

  function automatic int row(input int p);
    return (p / HT) - VST;
  endfunction

  logic m_nclk, m_run, m_fs;
  int   m_pos, m_cyc, m_x, m_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_nclk <= 1'b0;
      m_run  <= 1'b0;
      m_fs   <= 1'b0;
      m_pos  <= 0;
      m_cyc  <= 0;
      m_x    <= 0;
      m_y    <= 0;
    end else begin
      m_nclk <= !m_nclk;
      m_cyc  <= m_cyc + 1;
      m_fs   <= 1'b0;
      if (m_nclk) begin
        if (!m_run) begin
          if (bus.ena && m_cyc >= DLY) begin
            m_run <= 1'b1;
            m_pos <= 0;
            m_fs  <= 1'b1;
            if (vis(nxt(0))) begin
              m_x <= col(nxt(0));
              m_y <= row(nxt(0));
            end
          end
        end else if (nxt(m_pos) == 0 && !bus.ena) begin
          m_run <= 1'b0;
        end else begin
          m_pos <= nxt(m_pos);
          m_fs  <= (nxt(m_pos) == 0);
          if (vis(nxt(nxt(m_pos)))) begin
            m_x <= col(nxt(nxt(m_pos)));
            m_y <= row(nxt(nxt(m_pos)));
          end
        end
      end
    end
  end

  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("nclk",        bus.nclk,        m_nclk);
      check("pix_ce",      bus.pix_ce,      m_nclk);
      check("grest",       bus.grest,       m_cyc >= DLY);
      check("hd",          bus.hd,          m_run ? (m_pos % HT >= HS) : 1'b1);
      check("vd",          bus.vd,          m_run ? (m_pos / HT >= VS) : 1'b1);
      check("den",         bus.den,         m_run && vis(m_pos));
      check("pix_req",     bus.pix_req,     m_run && vis(nxt(m_pos)));
      check("x_next",      bus.x_next,      m_x);
      check("y_next",      bus.y_next,      m_y);
      check("frame_start", bus.frame_start, m_fs);
      check("running",     bus.running,     m_run);
    end
  end

  task automatic check_reset_values(input string pfx);
    check({pfx, "_nclk"},    bus.nclk,        0);
    check({pfx, "_grest"},   bus.grest,       0);
    check({pfx, "_hd"},      bus.hd,          1);
    check({pfx, "_vd"},      bus.vd,          1);
    check({pfx, "_den"},     bus.den,         0);
    check({pfx, "_pix_ce"},  bus.pix_ce,      0);
    check({pfx, "_pix_req"}, bus.pix_req,     0);
    check({pfx, "_x_next"},  bus.x_next,      0);
    check({pfx, "_y_next"},  bus.y_next,      0);
    check({pfx, "_fstart"},  bus.frame_start, 0);
    check({pfx, "_running"}, bus.running,     0);
  endtask

  // Called on the falling edge where reset was released; counts CLK edges until GREST.
  task automatic wait_grest(input string tag);
    int n    = 0;
    bit seen = 1'b0;
    for (int i = 0; i < DLY + 10 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.grest) seen = 1'b1;
    end
    check(tag, n, DLY);
  endtask

  int   n;
  int   den_cnt, hd_falls, hd_low, vd_low, req_cnt, first_req, den_after;
  int   fx, fy, lx, ly;
  logic prev_hd;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.ena = 1'b0;
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_values("reset");

    rst_n = 1'b1;
    wait_grest("grest_delay");
    check("idle_running", bus.running, 0);

    // Start a frame and gather one frame of tick-level statistics.
    bus.ena = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.running && n < 4);
    check("running_within_2clk", bus.running && (n <= 2), 1);
    check("frame_start_on_entry", bus.frame_start, 1);
    check("hd_falls_with_fstart", bus.hd, 0);

    den_cnt = 0; hd_falls = 0; hd_low = 0; vd_low = 0; req_cnt = 0;
    first_req = -1; den_after = 0; fx = -1; fy = -1; lx = -1; ly = -1;
    prev_hd = 1'b1;
    for (int t = 0; t < FT; t++) begin
      if (t > 0) repeat (2) @(negedge clk);
      den_cnt += int'(bus.den);
      if (prev_hd && !bus.hd) hd_falls++;
      prev_hd = bus.hd;
      hd_low += int'(!bus.hd);
      vd_low += int'(!bus.vd);
      if (first_req >= 0 && t == first_req + 1) den_after = int'(bus.den);
      if (bus.pix_req) begin
        req_cnt++;
        if (first_req < 0) begin
          first_req = t;
          fx = int'(bus.x_next);
          fy = int'(bus.y_next);
        end
        lx = int'(bus.x_next);
        ly = int'(bus.y_next);
      end
    end
    check("den_ticks_per_frame", den_cnt,   HA * VA);
    check("hd_periods",          hd_falls,  VT);
    check("hd_low_ticks",        hd_low,    HS * VT);
    check("vd_low_ticks",        vd_low,    VS * HT);
    check("req_ticks",           req_cnt,   HA * VA);
    check("first_req_tick",      first_req, VST * HT + HST - 1);
    check("first_req_x",         fx,        0);
    check("first_req_y",         fy,        0);
    check("den_after_first_req", den_after, 1);
    check("last_req_x",          lx,        HA - 1);
    check("last_req_y",          ly,        VA - 1);

    // Drop ENA mid-frame with a one-tick re-pulse; the frame must run out to IDLE.
    repeat ($urandom_range(20, FT - 20) * 2) @(negedge clk);
    bus.ena = 1'b0;
    repeat (6) @(negedge clk);
    bus.ena = 1'b1;
    repeat (2) @(negedge clk);
    bus.ena = 1'b0;
    for (n = 0; n < 4 * FT + 8 && bus.running; n++) @(negedge clk);
    check("frame_completes", bus.running, 0);
    check("idle_hd", bus.hd, 1);
    check("idle_vd", bus.vd, 1);

    // Random ENA activity, mixing short pulses with long levels.
    for (int i = 0; i < 30; i++) begin
      bus.ena = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      else repeat ($urandom_range(20, 400)) @(negedge clk);
    end

    // Reset in the middle of the visible area, then a full GREST delay again.
    bus.ena = 1'b1;
    for (n = 0; n < 4 * FT && !(m_run && (m_pos / HT) == 6); n++) @(negedge clk);
    check("running_before_reset", bus.running, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midframe_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_grest("grest_delay_again");
    repeat (2 * FT * 2) @(negedge clk);
    check("running_after_restart", bus.running, 1);
    bus.ena = 1'b0;
    repeat (2 * FT * 2) @(negedge clk);
    check("final_idle", bus.running, 0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
